// File: rtl/layer_op_sequencer_pkg.sv
// Shared types and constants for the layer operation sequencer.
// Q8.8 fixed point: ONE is 1.0, SAT_MAX/SAT_MIN bound the 16-bit result.
package layer_op_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      ACT,
      WRITE
   } opState_t;

   typedef enum logic [1:0] {
      ACT_IDENTITY = 2'b00,
      ACT_RELU     = 2'b01,
      ACT_CLAMP    = 2'b10,
      ACT_STEP     = 2'b11
   } actFunc_t;

   localparam logic [15:0] ONE     = 16'h0100;
   localparam logic [15:0] SAT_MAX = 16'h7FFF;
   localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/layer_op_sequencer_act.sv
// Combinational activation: rescale the Q8.8 accumulator, saturate to
// 16 bits and apply the selected activation function.
module act_unit
   import layer_op_sequencer_pkg::*;
#(
   parameter int unsigned dataW    = 16,
   parameter int unsigned accW     = 40,
   parameter int unsigned fracBits = 8
) (
   input  logic [accW-1:0]  acc,
   input  logic [1:0]       actFuncSel,
   output logic [dataW-1:0] result
);

   localparam logic signed [accW-1:0] SAT_MAX_W = accW'(signed'(SAT_MAX));
   localparam logic signed [accW-1:0] SAT_MIN_W = accW'(signed'(SAT_MIN));

   logic signed [accW-1:0] shifted;
   logic [dataW-1:0]       rSat;

   always_comb begin
      shifted = $signed(acc) >>> fracBits;
      if (shifted > SAT_MAX_W) begin
         rSat = SAT_MAX;
      end else if (shifted < SAT_MIN_W) begin
         rSat = SAT_MIN;
      end else begin
         rSat = shifted[dataW-1:0];
      end
   end

   // rSat sign bit decides every non-identity case; clamp upper bound is 1.0
   always_comb begin
      result = rSat;
      case (actFunc_t'(actFuncSel))
         ACT_IDENTITY: result = rSat;
         ACT_RELU:     result = rSat[dataW-1] ? '0 : rSat;
         ACT_CLAMP:    result = rSat[dataW-1] ? '0 : ((rSat > ONE) ? ONE : rSat);
         ACT_STEP:     result = rSat[dataW-1] ? '0 : ONE;
         default:      result = rSat;
      endcase
   end

endmodule

// File: rtl/layer_op_sequencer.sv
// Computes one neuron output: streams numOps layer/weight pairs from the
// cache banks, multiply-accumulates in Q8.8, activates and writes the result.
module layer_op_sequencer
   import layer_op_sequencer_pkg::*;
#(
   parameter int unsigned dataW    = 16,
   parameter int unsigned accW     = 40,
   parameter int unsigned fracBits = 8,
   parameter int unsigned readLat  = 1
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             beginOp,
   output logic             readyForNextOp,
   input  logic [15:0]      offset,
   input  logic [15:0]      dest,
   input  logic [15:0]      numOps,
   input  logic [1:0]       actFuncSel,
   input  logic             writeReverse,
   output logic [15:0]      layerRdAddr,
   output logic [15:0]      weightRdAddr,
   input  logic [dataW-1:0] layerRdData,
   input  logic [dataW-1:0] weightRdData,
   output logic             rdBankSel,
   output logic [15:0]      wrAddr,
   output logic [dataW-1:0] wrData,
   output logic             wrEn,
   output logic             busy
);

   localparam logic [readLat-1:0] LAST_STAGE = readLat'(1) << (readLat - 1);

   opState_t         state;
   logic [15:0]      offsetL;
   logic [15:0]      destL;
   logic [15:0]      numOpsL;
   logic [1:0]       actSelL;
   logic [15:0]      idx;
   logic [readLat-1:0] validPipe;
   logic [accW-1:0]  acc;

   logic signed [2*dataW-1:0] product;
   logic [accW-1:0]           productExt;
   logic [dataW-1:0]          actResult;

   assign product = $signed({{dataW{layerRdData[dataW-1]}}, layerRdData}) *
                    $signed({{dataW{weightRdData[dataW-1]}}, weightRdData});
   assign productExt = {{(accW-2*dataW){product[2*dataW-1]}}, product};

   act_unit #(
      .dataW    (dataW),
      .accW     (accW),
      .fracBits (fracBits)
   ) uAct (
      .acc        (acc),
      .actFuncSel (actSelL),
      .result     (actResult)
   );

   // validPipe tracks which issued addresses have data arriving this cycle;
   // readyForNextOp drops on the accepting edge and rises one cycle after
   // returning to IDLE, so it gates acceptance rather than the state alone.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state          <= IDLE;
         offsetL        <= '0;
         destL          <= '0;
         numOpsL        <= '0;
         actSelL        <= '0;
         rdBankSel      <= 1'b0;
         idx            <= '0;
         validPipe      <= '0;
         acc            <= '0;
         layerRdAddr    <= '0;
         weightRdAddr   <= '0;
         wrAddr         <= '0;
         wrData         <= '0;
         wrEn           <= 1'b0;
         busy           <= 1'b0;
         readyForNextOp <= 1'b1;
      end else begin
         wrEn      <= 1'b0;
         validPipe <= (validPipe << 1) | readLat'(state == ISSUE);
         if (validPipe[readLat-1]) begin
            acc <= acc + productExt;
         end

         case (state)
            IDLE: begin
               if (beginOp && readyForNextOp) begin
                  offsetL        <= offset;
                  destL          <= dest;
                  numOpsL        <= numOps;
                  actSelL        <= actFuncSel;
                  rdBankSel      <= writeReverse;
                  idx            <= '0;
                  acc            <= '0;
                  busy           <= 1'b1;
                  readyForNextOp <= 1'b0;
                  state          <= (numOps == '0) ? ACT : ISSUE;
               end else begin
                  busy           <= 1'b0;
                  readyForNextOp <= 1'b1;
               end
            end
            ISSUE: begin
               layerRdAddr  <= offsetL + idx;
               weightRdAddr <= idx;
               idx          <= idx + 16'd1;
               if (idx == numOpsL - 16'd1) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if ((validPipe & ~LAST_STAGE) == '0) begin
                  state <= ACT;
               end
            end
            ACT: begin
               wrData <= actResult;
               wrAddr <= destL;
               state  <= WRITE;
            end
            WRITE: begin
               wrEn  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_op_sequencer.sv
// Self-checking bench for layer_op_sequencer: table vectors, hand-written
// handshake/reset sequences and randomized ops against an arithmetic model.
module tb_layer_op_sequencer;

   logic        clk = 1'b0;
   logic        rstN;
   logic        beginOp;
   logic        readyForNextOp;
   logic [15:0] offset, dest, numOps;
   logic [1:0]  actFuncSel;
   logic        writeReverse;
   logic [15:0] layerRdAddr, weightRdAddr;
   logic [15:0] layerRdData, weightRdData;
   logic        rdBankSel;
   logic [15:0] wrAddr, wrData;
   logic        wrEn;
   logic        busy;

   logic [15:0] bankA [0:65535];
   logic [15:0] bankB [0:65535];
   logic [15:0] wBank [0:65535];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign layerRdData  = rdBankSel ? bankB[layerRdAddr] : bankA[layerRdAddr];
   assign weightRdData = wBank[weightRdAddr];

   layer_op_sequencer #(
      .dataW    (16),
      .accW     (40),
      .fracBits (8),
      .readLat  (1)
   ) dut (
      .clk            (clk),
      .rstN           (rstN),
      .beginOp        (beginOp),
      .readyForNextOp (readyForNextOp),
      .offset         (offset),
      .dest           (dest),
      .numOps         (numOps),
      .actFuncSel     (actFuncSel),
      .writeReverse   (writeReverse),
      .layerRdAddr    (layerRdAddr),
      .weightRdAddr   (weightRdAddr),
      .layerRdData    (layerRdData),
      .weightRdData   (weightRdData),
      .rdBankSel      (rdBankSel),
      .wrAddr         (wrAddr),
      .wrData         (wrData),
      .wrEn           (wrEn),
      .busy           (busy)
   );

   typedef struct {
      int               n;
      logic [15:0]      off;
      logic [15:0]      dst;
      logic [1:0]       act;
      logic             rev;
      logic [3:0][15:0] lay;
      logic [3:0][15:0] wt;
      logic [15:0]      exp;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: exact dot product, floor-divide by 256, saturate, activate.
   function automatic logic [15:0] model(input int n, input logic [15:0] off,
                                         input logic [1:0] act, input logic rev);
      longint sum = 0;
      longint r;
      logic [15:0] a, w, idx;
      for (int i = 0; i < n; i++) begin
         idx = off + 16'(i);
         a   = rev ? bankB[idx] : bankA[idx];
         w   = wBank[i];
         sum += longint'($signed(a)) * longint'($signed(w));
      end
      r = sum >>> 8;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      case (act)
         2'b00: return 16'(r);
         2'b01: return (r < 0) ? 16'h0000 : 16'(r);
         2'b10: return (r < 0) ? 16'h0000 : ((r > 256) ? 16'h0100 : 16'(r));
         default: return (r < 0) ? 16'h0000 : 16'h0100;
      endcase
   endfunction

   task automatic waitIdle(input string name);
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (readyForNextOp) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check({name, " idle timeout"}, 0, 1);
   endtask

   task automatic loadVec(input int n, input logic [15:0] off, input logic rev,
                          input logic [3:0][15:0] lay, input logic [3:0][15:0] wt);
      logic [15:0] idx;
      for (int j = 0; j < n; j++) begin
         idx = off + 16'(j);
         if (rev) begin
            bankB[idx] = lay[j];
            bankA[idx] = 16'($urandom);
         end else begin
            bankA[idx] = lay[j];
            bankB[idx] = 16'($urandom);
         end
         wBank[j] = wt[j];
      end
   endtask

   // One full op: inputs are scrambled after acceptance and a stray beginOp
   // is pulsed mid-op; exactly one write with correct timing is required.
   task automatic runOp(input string name, input int n, input logic [15:0] off,
                        input logic [15:0] dst, input logic [1:0] act,
                        input logic rev, input logic [15:0] expData);
      int wrCount = 0, wrCycle = -1, rdyCycle = -1, addrErr = 0, bankErr = 0;
      logic [15:0] gotData = '0, gotAddr = '0;
      @(negedge clk);
      offset = off; dest = dst; numOps = 16'(n);
      actFuncSel = act; writeReverse = rev; beginOp = 1'b1;
      @(negedge clk);
      beginOp = 1'b0;
      offset = ~off; dest = ~dst; numOps = 16'($urandom_range(1, 50));
      actFuncSel = ~act; writeReverse = ~rev;
      for (int m = 0; m < 300; m++) begin
         if (m >= 1 && m <= n) begin
            if (layerRdAddr !== off + 16'(m - 1) || weightRdAddr !== 16'(m - 1)) addrErr++;
         end
         if (!readyForNextOp && rdBankSel !== rev) bankErr++;
         if (wrEn) begin
            wrCount++; wrCycle = m; gotData = wrData; gotAddr = wrAddr;
         end
         if (readyForNextOp) begin
            rdyCycle = m;
            break;
         end
         beginOp = (m == 2);
         @(negedge clk);
      end
      beginOp = 1'b0;
      for (int m = 0; m < 3; m++) begin
         @(negedge clk);
         if (wrEn) wrCount++;
      end
      check({name, " ready returned"}, rdyCycle >= 0, 1);
      check({name, " wrData"}, gotData, expData);
      check({name, " wrAddr"}, gotAddr, dst);
      check({name, " write count"}, wrCount, 1);
      check({name, " wrEn cycle"}, wrCycle, (n == 0) ? 2 : n + 3);
      if (n > 0) check({name, " ready cycle"}, rdyCycle, n + 4);
      check({name, " address errors"}, addrErr, 0);
      check({name, " rdBankSel errors"}, bankErr, 0);
   endtask

   initial begin
      int wrCount, dataErr;
      int n;
      logic [15:0] off, dst, e;
      logic [1:0] act;
      logic rev;
      logic [3:0][15:0] lay, wt;

      for (int i = 0; i < 65536; i++) begin
         bankA[i] = '0; bankB[i] = '0; wBank[i] = '0;
      end

      rstN = 1'b0; beginOp = 1'b0; offset = '0; dest = '0; numOps = '0;
      actFuncSel = '0; writeReverse = 1'b0;
      #17;
      rstN = 1'b1;
      @(negedge clk);
      check("reset ready", readyForNextOp, 1);
      check("reset busy", busy, 0);
      check("reset wrEn", wrEn, 0);
      check("reset addrs", {layerRdAddr, weightRdAddr}, 0);
      check("reset wrData/wrAddr", {wrData, wrAddr}, 0);
      check("reset rdBankSel", rdBankSel, 0);

      tbl[0]  = '{3, 16'h0010, 16'h0042, 2'b00, 1'b0, {16'h0, 16'hFF00, 16'h0200, 16'h0100}, {16'h0, 16'h0100, 16'h0080, 16'h0080}, 16'h0080};
      tbl[1]  = '{3, 16'h0010, 16'h0043, 2'b01, 1'b0, {16'h0, 16'hFF00, 16'h0200, 16'h0100}, {16'h0, 16'h0100, 16'h0000, 16'h0000}, 16'h0000};
      tbl[2]  = '{3, 16'h0010, 16'h0044, 2'b11, 1'b0, {16'h0, 16'hFF00, 16'h0200, 16'h0100}, {16'h0, 16'h0100, 16'h0000, 16'h0000}, 16'h0000};
      tbl[3]  = '{3, 16'h0010, 16'h0045, 2'b11, 1'b0, {16'h0, 16'h0100, 16'h0200, 16'h0100}, {16'h0, 16'h0100, 16'h0000, 16'h0000}, 16'h0100};
      tbl[4]  = '{4, 16'h1230, 16'h0100, 2'b00, 1'b1, {4{16'h7FFF}}, {4{16'h7FFF}}, 16'h7FFF};
      tbl[5]  = '{4, 16'h1230, 16'h0101, 2'b00, 1'b0, {4{16'h7FFF}}, {4{16'h8000}}, 16'h8000};
      tbl[6]  = '{4, 16'h1230, 16'h0102, 2'b10, 1'b1, {4{16'h7FFF}}, {4{16'h7FFF}}, 16'h0100};
      tbl[7]  = '{0, 16'h0000, 16'h0200, 2'b11, 1'b0, {4{16'h0}}, {4{16'h0}}, 16'h0100};
      tbl[8]  = '{0, 16'h0000, 16'h0201, 2'b00, 1'b1, {4{16'h0}}, {4{16'h0}}, 16'h0000};
      tbl[9]  = '{2, 16'hFFFF, 16'h0300, 2'b01, 1'b0, {16'h0, 16'h0, 16'h0040, 16'h0300}, {16'h0, 16'h0, 16'h0200, 16'h0100}, 16'h0380};
      tbl[10] = '{1, 16'h0400, 16'h0301, 2'b10, 1'b1, {16'h0, 16'h0, 16'h0, 16'h0080}, {16'h0, 16'h0, 16'h0, 16'h0100}, 16'h0080};
      tbl[11] = '{1, 16'h0400, 16'h0302, 2'b00, 1'b0, {16'h0, 16'h0, 16'h0, 16'hFFFF}, {16'h0, 16'h0, 16'h0, 16'h0001}, 16'hFFFF};

      for (int i = 0; i < 12; i++) begin
         loadVec(tbl[i].n, tbl[i].off, tbl[i].rev, tbl[i].lay, tbl[i].wt);
         runOp($sformatf("vec%0d", i), tbl[i].n, tbl[i].off, tbl[i].dst,
               tbl[i].act, tbl[i].rev, tbl[i].exp);
      end

      // beginOp held high: ops accepted at k, k+7, k+14 for N=2
      waitIdle("held");
      loadVec(2, 16'h0500, 1'b0, {16'h0, 16'h0, 16'h0100, 16'h0100}, {16'h0, 16'h0, 16'h0100, 16'h0100});
      @(negedge clk);
      offset = 16'h0500; dest = 16'h0600; numOps = 16'd2; actFuncSel = 2'b00;
      writeReverse = 1'b0; beginOp = 1'b1;
      wrCount = 0; dataErr = 0;
      for (int m = 0; m <= 20; m++) begin
         @(negedge clk);
         if (wrEn) begin
            wrCount++;
            if (wrData !== 16'h0200) dataErr++;
         end
      end
      beginOp = 1'b0;
      @(negedge clk);
      check("held write count", wrCount, 3);
      check("held data errors", dataErr, 0);
      check("held idle after drop", {readyForNextOp, busy}, 2'b10);

      // asynchronous reset during ISSUE
      waitIdle("reset");
      loadVec(4, 16'h0100, 1'b1, {4{16'h0100}}, {4{16'h0100}});
      @(negedge clk);
      offset = 16'h0100; dest = 16'h0700; numOps = 16'd8; actFuncSel = 2'b00;
      writeReverse = 1'b1; beginOp = 1'b1;
      @(negedge clk);
      beginOp = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre-reset busy", busy, 1);
      #2 rstN = 1'b0;
      #1;
      check("midreset ready/busy/wrEn", {readyForNextOp, busy, wrEn}, 3'b100);
      check("midreset addrs", {layerRdAddr, weightRdAddr}, 0);
      check("midreset wrData/wrAddr", {wrData, wrAddr}, 0);
      check("midreset rdBankSel", rdBankSel, 0);
      @(negedge clk);
      rstN = 1'b1;
      wrCount = 0;
      for (int m = 0; m < 15; m++) begin
         @(negedge clk);
         if (wrEn) wrCount++;
      end
      check("post-reset no write", wrCount, 0);
      loadVec(tbl[0].n, tbl[0].off, tbl[0].rev, tbl[0].lay, tbl[0].wt);
      runOp("after reset", tbl[0].n, tbl[0].off, tbl[0].dst, tbl[0].act, tbl[0].rev, tbl[0].exp);

      for (int r = 0; r < 25; r++) begin
         n   = $urandom_range(0, 12);
         off = 16'($urandom);
         dst = 16'($urandom);
         act = 2'($urandom);
         rev = 1'($urandom);
         for (int j = 0; j < n; j++) begin
            bankA[off + 16'(j)] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
            bankB[off + 16'(j)] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
            wBank[j]            = (r % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
         end
         e = model(n, off, act, rev);
         runOp($sformatf("rand%0d", r), n, off, dst, act, rev, e);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
